// File: rtl/ed25519_stream_ctrl.sv
// rtl/ed25519_stream_ctrl.sv - job-level stream controller for the ECC datapath
// Collects IN_WORDS words per job, launches the engine, and streams OUT_WORDS result words out.
module ed25519_stream_ctrl #(
    parameter int DATA_W    = 64,
    parameter int IN_WORDS  = 12,
    parameter int OUT_WORDS = 8,
    parameter int PREFETCH  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_in_valid,
    input  logic [DATA_W-1:0]             i_in_data,
    output logic                          o_in_ready,
    output logic                          o_out_valid,
    output logic [DATA_W-1:0]             o_out_data,
    input  logic                          i_out_ready,
    output logic                          o_eng_start,
    output logic [IN_WORDS*DATA_W-1:0]    o_eng_operand,
    input  logic                          i_eng_done,
    input  logic [OUT_WORDS*DATA_W-1:0]   i_eng_result,
    output logic                          o_busy,
    output logic [15:0]                   o_job_cnt
);

    localparam int OP_W  = IN_WORDS * DATA_W;
    localparam int RES_W = OUT_WORDS * DATA_W;
    localparam int ICW   = $clog2(IN_WORDS + 1);
    localparam int OCW   = $clog2(OUT_WORDS + 1);
    localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_WORDS - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_WORDS - 1);
    localparam logic PF = (PREFETCH != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic                   started_q;
    logic                   in_ready_q;
    logic [1:0][OP_W-1:0]   buf_q;
    logic [1:0]             full_q;
    logic [1:0]             full_nxt;
    logic                   fill_ptr;
    logic                   fill_ptr_nxt;
    logic                   exec_ptr;
    logic [ICW-1:0]         word_cnt;
    logic [1:0]             state_q;
    logic [OP_W-1:0]        operand_q;
    logic [RES_W-1:0]       result_q;
    logic [OCW-1:0]         out_cnt;
    logic [15:0]            job_cnt_q;

    logic in_fire;
    logic in_last;
    logic done_fire;
    logic out_fire;
    logic out_last;

    assign in_fire   = i_in_valid && in_ready_q;
    assign in_last   = in_fire && (word_cnt == IN_LAST);
    assign done_fire = (state_q == S_WAIT) && i_eng_done;
    assign out_fire  = (state_q == S_DRAIN) && i_out_ready;
    assign out_last  = out_fire && (out_cnt == OUT_LAST);

    // The filling buffer is never the exec buffer while that one is full, so both updates can land together.
    always_comb begin
        full_nxt = full_q;
        if (done_fire) full_nxt[exec_ptr] = 1'b0;
        if (in_last)   full_nxt[fill_ptr] = 1'b1;
    end

    assign fill_ptr_nxt = fill_ptr ^ (in_last & PF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            started_q  <= 1'b0;
            in_ready_q <= 1'b0;
            buf_q      <= '0;
            full_q     <= '0;
            fill_ptr   <= 1'b0;
            exec_ptr   <= 1'b0;
            word_cnt   <= '0;
            state_q    <= S_IDLE;
            operand_q  <= '0;
            result_q   <= '0;
            out_cnt    <= '0;
            job_cnt_q  <= '0;
        end else begin
            started_q  <= 1'b1;
            // Ready is registered from next-state flags so no input reaches it combinationally.
            in_ready_q <= started_q && !full_nxt[fill_ptr_nxt];
            full_q     <= full_nxt;
            fill_ptr   <= fill_ptr_nxt;

            if (in_fire) begin
                buf_q[fill_ptr] <= {buf_q[fill_ptr][OP_W-DATA_W-1:0], i_in_data};
                word_cnt        <= in_last ? '0 : word_cnt + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (full_q[exec_ptr]) begin
                        operand_q <= buf_q[exec_ptr];
                        state_q   <= S_START;
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_eng_done) begin
                        result_q <= i_eng_result;
                        exec_ptr <= exec_ptr ^ PF;
                        out_cnt  <= '0;
                        state_q  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        result_q <= result_q << DATA_W;
                        out_cnt  <= out_cnt + 1'b1;
                        if (out_last) begin
                            job_cnt_q <= job_cnt_q + 16'd1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready    = in_ready_q;
    assign o_out_valid   = (state_q == S_DRAIN);
    assign o_out_data    = result_q[RES_W-1 -: DATA_W];
    assign o_eng_start   = (state_q == S_START);
    assign o_eng_operand = operand_q;
    assign o_busy        = (|full_q) || (state_q != S_IDLE);
    assign o_job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_ed25519_stream_ctrl.sv
// tb/tb_ed25519_stream_ctrl.sv - self-checking bench for ed25519_stream_ctrl
// Index 0 is a single-buffer instance, index 1 a prefetching instance; both share clock and reset.
module tb_ed25519_stream_ctrl;

    localparam int DATA_W    = 64;
    localparam int IN_WORDS  = 12;
    localparam int OUT_WORDS = 8;
    localparam int OP_W      = IN_WORDS * DATA_W;
    localparam int RES_W     = OUT_WORDS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid    [2];
    logic [DATA_W-1:0] in_data     [2];
    logic              in_ready    [2];
    logic              out_valid   [2];
    logic [DATA_W-1:0] out_data    [2];
    logic              out_ready   [2];
    logic              eng_start   [2];
    logic [OP_W-1:0]   eng_operand [2];
    logic              eng_done    [2];
    logic [RES_W-1:0]  eng_result  [2];
    logic              busy        [2];
    logic [15:0]       job_cnt     [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat [2] = '{20, 10};
    logic [3:0] rdy_pat [2] = '{4'hF, 4'hF};
    int done_last [2] = '{0, 0};
    int words [2] = '{0, 0};

    logic [OP_W-1:0]   exp_op  [2][$];
    logic [DATA_W-1:0] exp_out [2][$];
    int start_log [2][$];
    int done_log  [2][$];
    int drain_log [2][$];

    ed25519_stream_ctrl #(.DATA_W(DATA_W), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS), .PREFETCH(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid[0]), .i_in_data(in_data[0]), .o_in_ready(in_ready[0]),
        .o_out_valid(out_valid[0]), .o_out_data(out_data[0]), .i_out_ready(out_ready[0]),
        .o_eng_start(eng_start[0]), .o_eng_operand(eng_operand[0]),
        .i_eng_done(eng_done[0]), .i_eng_result(eng_result[0]),
        .o_busy(busy[0]), .o_job_cnt(job_cnt[0])
    );

    ed25519_stream_ctrl #(.DATA_W(DATA_W), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS), .PREFETCH(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid[1]), .i_in_data(in_data[1]), .o_in_ready(in_ready[1]),
        .o_out_valid(out_valid[1]), .o_out_data(out_data[1]), .i_out_ready(out_ready[1]),
        .o_eng_start(eng_start[1]), .o_eng_operand(eng_operand[1]),
        .i_eng_done(eng_done[1]), .i_eng_result(eng_result[1]),
        .o_busy(busy[1]), .o_job_cnt(job_cnt[1])
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_env
        // Engine model: result is the top OUT_WORDS words of the operand, returned lat cycles after start.
        initial begin : eng_proc
            logic [OP_W-1:0] op;
            bit aborted;
            eng_done[g]   = 1'b0;
            eng_result[g] = '0;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && eng_start[g] === 1'b1) begin
                    start_log[g].push_back(cyc);
                    if (exp_op[g].size() == 0) begin
                        check("start_unexpected", eng_start[g], 0);
                        op = '0;
                    end else begin
                        op = exp_op[g].pop_front();
                        check("operand", eng_operand[g], op);
                    end
                    aborted = 1'b0;
                    for (int k = 0; k < lat[g]; k++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k == 0) check("start_pulse_width", eng_start[g], 0);
                    end
                    if (!aborted) begin
                        done_last[g] = cyc;
                        done_log[g].push_back(cyc);
                        check("operand_hold", eng_operand[g], op);
                        eng_result[g] = op[OP_W-1 -: RES_W];
                        eng_done[g]   = 1'b1;
                        @(negedge clk);
                        eng_done[g]   = 1'b0;
                    end
                end
            end
        end

        initial begin : sink_proc
            int idx;
            idx = 0;
            out_ready[g] = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                out_ready[g] = rdy_pat[g][idx % 4];
                idx++;
            end
        end

        initial begin : mon_proc
            bit prev;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    prev = 1'b0;
                end else begin
                    if (out_valid[g] === 1'b1) begin
                        if (!prev) check("out_latency", cyc, done_last[g] + 1);
                        if (exp_out[g].size() == 0) begin
                            check("out_unexpected", out_valid[g], 0);
                        end else begin
                            check("out_data", out_data[g], exp_out[g][0]);
                            if (out_ready[g] === 1'b1) begin
                                void'(exp_out[g].pop_front());
                                words[g]++;
                                if (words[g] % OUT_WORDS == 0) drain_log[g].push_back(cyc);
                            end
                        end
                    end
                    prev = (out_valid[g] === 1'b1);
                end
            end
        end
    end

    task automatic clear_logs();
        for (int s = 0; s < 2; s++) begin
            start_log[s].delete();
            done_log[s].delete();
            drain_log[s].delete();
        end
    endtask

    task automatic reset_dut();
        for (int s = 0; s < 2; s++) in_valid[s] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        clear_logs();
        for (int s = 0; s < 2; s++) begin
            exp_op[s].delete();
            exp_out[s].delete();
            words[s] = 0;
            check("rst_in_ready", in_ready[s], 0);
            check("rst_out_valid", out_valid[s], 0);
            check("rst_out_data", out_data[s], 0);
            check("rst_eng_start", eng_start[s], 0);
            check("rst_operand", eng_operand[s], 0);
            check("rst_busy", busy[s], 0);
            check("rst_job_cnt", job_cnt[s], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) check("rel_ready_c0", in_ready[s], 0);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rel_ready_c1", in_ready[s], 0);
            check("rel_busy", busy[s], 0);
            check("rel_job_cnt", job_cnt[s], 0);
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) check("rel_ready_c2", in_ready[s], 1);
        @(posedge clk); #1;
    endtask

    task automatic send_job(input int s, input int n, input bit gaps, input bit model,
                            output int first_hs, output int last_hs);
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] w;
        bit ok;
        op = '0;
        first_hs = -1;
        last_hs  = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid[s] = 1'b0;
                @(posedge clk); #1;
            end
            w  = {$urandom(), 32'(i + 1)};
            op = {op[OP_W-DATA_W-1:0], w};
            in_valid[s] = 1'b1;
            in_data[s]  = w;
            ok = 1'b0;
            for (int t = 0; t < 4000; t++) begin
                @(negedge clk);
                if (in_ready[s] === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("in_handshake_timeout", ok, 1);
            if (i == 0) first_hs = cyc;
            last_hs = cyc;
            @(posedge clk); #1;
        end
        in_valid[s] = 1'b0;
        if (model) begin
            exp_op[s].push_back(op);
            for (int k = 0; k < OUT_WORDS; k++) exp_out[s].push_back(op[OP_W-1-k*DATA_W -: DATA_W]);
        end
    endtask

    task automatic wait_idle(input int s);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (exp_out[s].size() == 0 && exp_op[s].size() == 0 && out_valid[s] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int f, la, lb, fb, fc;
        bit ok;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            in_data[s]  = '0;
        end
        reset_dut();

        // Single job, no backpressure, engine latency 10.
        lat[1] = 10;
        send_job(1, IN_WORDS, 1'b1, 1'b1, f, la);
        wait_idle(1);
        check("t1_start_latency", start_log[1][0], la + 2);
        check("t1_job_cnt", job_cnt[1], 1);

        // Output backpressure 1,0,0,1.
        clear_logs();
        rdy_pat[1] = 4'b1001;
        send_job(1, IN_WORDS, 1'b1, 1'b1, f, la);
        wait_idle(1);
        rdy_pat[1] = 4'hF;
        check("t2_job_cnt", job_cnt[1], 2);

        // Two back-to-back jobs with long engine latency.
        clear_logs();
        lat[1] = 50;
        send_job(1, IN_WORDS, 1'b0, 1'b1, f, la);
        send_job(1, IN_WORDS, 1'b0, 1'b1, f, lb);
        wait_idle(1);
        check("t3_b_filled_in_wait", (lb < done_log[1][0]), 1);
        check("t3_second_start", start_log[1][1], drain_log[1][0] + 2);
        check("t3_job_cnt", job_cnt[1], 4);

        // Three jobs offered continuously: the third stalls until the first completes.
        clear_logs();
        lat[1] = 30;
        send_job(1, IN_WORDS, 1'b0, 1'b1, f, la);
        send_job(1, IN_WORDS, 1'b0, 1'b1, f, lb);
        send_job(1, IN_WORDS, 1'b0, 1'b1, fc, f);
        check("t4_third_stall", fc, done_log[1][0] + 1);
        wait_idle(1);
        check("t4_job_cnt", job_cnt[1], 7);

        // Single buffer: no input accepted between the last word and the cycle after done.
        clear_logs();
        lat[0] = 20;
        send_job(0, IN_WORDS, 1'b0, 1'b1, f, la);
        send_job(0, IN_WORDS, 1'b0, 1'b1, fb, lb);
        check("t5_refill_after_done", fb, done_log[0][0] + 1);
        wait_idle(0);
        check("t5_job_cnt", job_cnt[0], 2);

        // Reset while waiting on the engine with a partial next job buffered.
        clear_logs();
        lat[1] = 1000;
        send_job(1, IN_WORDS, 1'b0, 1'b1, f, la);
        send_job(1, 5, 1'b0, 1'b0, f, lb);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (start_log[1].size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_started", ok, 1);
        repeat (3) @(negedge clk);
        check("t6_busy_in_wait", busy[1], 1);
        reset_dut();
        eng_result[1] = {16{$urandom()}};
        eng_done[1]   = 1'b1;
        @(posedge clk); #1;
        eng_done[1]   = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_spurious_valid", out_valid[1], 0);
        check("t6_spurious_busy", busy[1], 0);
        check("t6_spurious_cnt", job_cnt[1], 0);
        @(posedge clk); #1;
        lat[1] = 10;
        send_job(1, IN_WORDS, 1'b1, 1'b1, f, la);
        wait_idle(1);
        check("t6_fresh_start", start_log[1][0], la + 2);
        check("t6_job_cnt", job_cnt[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ed25519_stream_ctrl.md
Name: ed25519_stream_ctrl

Overview:
Parametrised job-level stream controller for the ECC datapath. It collects IN_WORDS input words into an operand, launches an external compute engine with a start/done handshake, and streams OUT_WORDS result words out. This generation adds three things: configurable widths and word counts, an optional second input buffer so the next job loads while the engine runs, and an output that stays valid and stable until the sink accepts each word. It sits between the 64-bit I/O shell and the ScalarMul/Reduction engine chain.

Parameters:
DATA_W, 64, stream word width in bits
IN_WORDS, 12, words per input job (operand = IN_WORDS*DATA_W bits)
OUT_WORDS, 8, words per result (result = OUT_WORDS*DATA_W bits)
PREFETCH, 1, 1 = two input buffers (ping-pong), 0 = single buffer

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_in_valid  in  1  input word valid
i_in_data  in  DATA_W  input word
o_in_ready  out  1  input word accepted when valid&&ready
o_out_valid  out  1  result word valid
o_out_data  out  DATA_W  result word
i_out_ready  in  1  sink accepts result word
o_eng_start  out  1  one-cycle engine launch pulse
o_eng_operand  out  IN_WORDS*DATA_W  operand, stable from start until done
i_eng_done  in  1  engine finished; i_eng_result valid this cycle
i_eng_result  in  OUT_WORDS*DATA_W  engine result
o_busy  out  1  any buffer full, or core FSM not IDLE
o_job_cnt  out  16  completed jobs, wraps 0xFFFF->0

Behaviour:
- Reset: all state is cleared asynchronously. The following are 0 during reset and in the first cycle after release: o_in_ready, o_out_valid, o_out_data, o_eng_start, o_eng_operand, o_busy, o_job_cnt. o_in_ready rises in the second cycle after release.
- Word order: the first input word fills operand bits [IN_WORDS*DATA_W-1 -: DATA_W], descending from there. Output word k is i_eng_result[OUT_WORDS*DATA_W-1-k*DATA_W -: DATA_W].
- Fill side:
  - The fill pointer selects a buffer. o_in_ready = (that buffer not full), derived from registers only; there is no combinational path from any input to o_in_ready.
  - A handshake writes the word and increments the word counter.
  - On the IN_WORDS-th handshake the buffer is marked full, the counter clears, and the fill pointer toggles (PREFETCH=1 only).
- Core FSM states: IDLE, START, WAIT, DRAIN.
  - IDLE -> START when the exec-pointer buffer is full.
  - START: o_eng_start=1 for exactly one cycle; o_eng_operand = exec buffer contents. -> WAIT.
  - WAIT: on i_eng_done, latch i_eng_result into the output register, clear the exec buffer's full flag, toggle the exec pointer (PREFETCH=1), -> DRAIN. i_eng_done in any other state is ignored.
  - DRAIN: o_out_valid=1 and o_out_data = current word. Data holds stable while i_out_ready=0. Each handshake advances the word. The OUT_WORDS-th handshake increments o_job_cnt, drops o_out_valid next cycle, and returns to IDLE.
- Latency: last input handshake at cycle T -> o_eng_start high at T+2 (core idle). i_eng_done at cycle D -> o_out_valid with word 0 at D+1. Each further word may be consumed one per cycle.
- o_eng_operand holds from START until the cycle after done, even while the other buffer fills.
- Buffer release and reuse:
  - A full flag cleared on done allows that buffer to accept data from the following cycle.
  - PREFETCH=0: o_in_ready stays 0 from the IN_WORDS-th handshake until the cycle after done. Input never overlaps the engine.
  - PREFETCH=1: both buffers full -> o_in_ready=0. A third job stalls until done frees a buffer.
- Simultaneous events: a fill handshake and an engine done in the same cycle both take effect. The filling buffer is never the exec buffer while the exec buffer is full.
- A partially filled buffer is retained indefinitely; i_in_valid gaps are allowed.
- Reset mid-job (any state): everything aborts, partial words are discarded, o_job_cnt returns to 0.

Test Plan:
- Single job, DATA_W=64, IN_WORDS=12, OUT_WORDS=8, words 0x..01..0x..0C; engine returns done 10 cycles after start with result = operand[767:256] -> o_eng_start at T+2; 8 output words equal to operand words 1..8 in order; o_job_cnt=1.
- Output backpressure: i_out_ready toggles 1,0,0,1 -> o_out_data stable during stalls; no word lost or duplicated; o_out_valid stays 1 until the 8th handshake.
- PREFETCH=1, two jobs back-to-back, engine latency 50 cycles -> second job fully accepted during WAIT; its o_eng_start 2 cycles after the first job's DRAIN completes; results in order; o_job_cnt=2.
- PREFETCH=1, three jobs offered continuously -> o_in_ready=0 after job 2 completes filling, until job 1 done+1; job 3 data intact.
- PREFETCH=0 -> o_in_ready=0 from the 12th handshake until the cycle after i_eng_done.
- Reset asserted in WAIT with 5 words of the next job buffered -> all outputs 0 after reset; a fresh 12-word job produces the correct result; the stale 5 words do not appear; spurious i_eng_done in IDLE is ignored.
